mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Multicycle MIPS main control FSM, directly upstream of the byte-addressed big-endian word memory.
- Sequences fetch, decode, execute, memory and writeback for each instruction, one state per clock.
- Generates the memory strobes (memread, memwrite), the address-select (iord) and all datapath enables/muxes.
- Memory is combinational-read and commits writes on posedge clk, so no wait states.

Parameters:
ILLEGAL_HALT, 0, 1: an unknown opcode enters HALT permanently; 0: it is treated as NOP and control returns to FETCH.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  single clock; all state changes on posedge.
rst_n  in  1  asynchronous active-low reset.
opcode  in  6  IR[31:26], valid from DECODE onward.
zero  in  1  ALU zero flag, sampled combinationally in BEQ_EX.
memread  out  1  memory read strobe.
memwrite  out  1  memory write strobe (one cycle).
iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
irwrite  out  1  instruction register load enable.
pc_en  out  1  PC load: pcwrite | (branch & zero).
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
alusrca  out  1  0 = PC, 1 = register A.
alusrcb  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
aluop  out  2  00 = add, 01 = sub, 10 = use funct.
regdst  out  1  0 = rt, 1 = rd.
memtoreg  out  1  0 = ALUOut, 1 = MDR.
regwrite  out  1  register file write enable.
illegal  out  1  sticky: an unknown opcode has been decoded.
halted  out  1  FSM is in HALT.
state  out  4  current state encoding, for debug.
instr_retired  out  CNT_W  count of completed instructions.

Behaviour:
- Moore FSM: registered state; every control output is decoded from state only, except pc_en, which also uses zero.
- Reset (rst_n low, asynchronous):
  - state = IDLE(0), illegal = 0, instr_retired = 0.
  - All strobes, enables and mux outputs are 0.
  - The first posedge after rst_n rises moves IDLE to FETCH.
- Encodings and active outputs (all unlisted outputs are 0):
  - FETCH(1): memread=1, iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, pc_en=1. Always goes to DECODE.
  - DECODE(2): alusrcb=11, aluop=00 (branch target into ALUOut). Dispatch on opcode: 100011 lw and 101011 sw to MEMADR; 000000 to RTYPE_EX; 000100 to BEQ_EX; 001000 to ADDI_EX; 000010 to J_EX; any other opcode to ILLEGAL handling.
  - MEMADR(3): alusrca=1, alusrcb=10, aluop=00. lw goes to MEMRD, sw goes to MEMWR.
  - MEMRD(4): memread=1, iord=1. Goes to MEMWB.
  - MEMWB(5): regdst=0, memtoreg=1, regwrite=1. Goes to FETCH.
  - MEMWR(6): memwrite=1, iord=1 for exactly one cycle; memory commits at the closing edge. Goes to FETCH.
  - RTYPE_EX(7): alusrca=1, alusrcb=00, aluop=10. Goes to RTYPE_WB.
  - RTYPE_WB(8): regdst=1, memtoreg=0, regwrite=1. Goes to FETCH.
  - BEQ_EX(9): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pc_en=zero. Goes to FETCH.
  - ADDI_EX(10): alusrca=1, alusrcb=10, aluop=00. Goes to ADDI_WB.
  - ADDI_WB(11): regdst=0, memtoreg=0, regwrite=1. Goes to FETCH.
  - J_EX(12): pcsrc=10, pc_en=1. Goes to FETCH.
  - HALT(15): all outputs 0, halted=1. The only exit is reset.
- Latencies in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Retirement: instr_retired increments on the edge leaving MEMWB, MEMWR, RTYPE_WB, BEQ_EX, ADDI_WB or J_EX. It wraps modulo 2^CNT_W. Illegal opcodes do not increment it.
- Illegal opcode: set illegal in DECODE on the edge it is detected. With ILLEGAL_HALT=0 go to FETCH; with 1 go to HALT.
- memread and memwrite are never both 1 in the same cycle. irwrite is 1 only in FETCH.
- Reset mid-instruction (including mid-MEMWR) forces IDLE immediately, and memwrite drops asynchronously.

Test Plan:
- Reset and bring-up: hold rst_n low for 3 cycles, then release. Required: state=0 and all outputs 0 while low; FETCH with memread=1, irwrite=1, pc_en=1 one cycle after release.
- R-type: memory word 0 = 0x00430822 (sub). Required: state sequence 1,2,7,8,1; aluop=10 in RTYPE_EX; regdst=1 and regwrite=1 in RTYPE_WB; instr_retired goes 0 to 1.
- Load: word 4 = 0x8CA40006 (lw). Required: sequence 1,2,3,4,5,1; iord=1 and memread=1 in MEMRD; memtoreg=1 in MEMWB; 5 cycles total.
- Store and beq: opcode 101011 gives MEMWR with exactly one memwrite pulse and memread=0. Opcode 000100 with zero=1 gives pc_en=1 in BEQ_EX; with zero=0 it gives pc_en=0.
- Illegal opcode 111111: with ILLEGAL_HALT=0, illegal=1, next state FETCH, counter unchanged. With ILLEGAL_HALT=1, state=15 and halted=1 until rst_n is pulsed.
- Async reset: drop rst_n mid-MEMWR. Required: memwrite=0 before the next edge, state=0, instr_retired=0.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes all datapath strobes, enables and mux selects from the current state.
module mips_mc_control #(
    parameter bit          ILLEGAL_HALT = 1'b0,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             memread,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             pc_en,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             illegal,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_retired
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BEQ_EX   = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_J_EX     = 4'd12,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               pcwrite, branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_BEQ:       state_d = S_BEQ_EX;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_J_EX;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                endcase
            end
            // IR still holds the instruction, so opcode separates lw from sw here
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    state_d = S_MEMWB;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_MEMWB, S_MEMWR, S_RTYPE_WB, S_BEQ_EX, S_ADDI_WB, S_J_EX: begin
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        pcsrc    = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                irwrite = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
            end
            S_DECODE:   alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_RTYPE_EX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPE_WB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQ_EX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDI_EX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDI_WB:  regwrite = 1'b1;
            S_J_EX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            S_HALT:     halted = 1'b1;
            default:    ;
        endcase
    end

    assign pc_en         = pcwrite | (branch & zero);
    assign illegal       = illegal_q;
    assign state         = state_q;
    assign instr_retired = retired_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: two instances (illegal opcode as NOP / as HALT)
// run the same instruction stream; expectations are queued and checked each cycle.
module tb_mips_mc_control;

    logic clk = 1'b0;
    logic rst_n;
    logic [5:0] opcode;
    logic zero;

    always #5 clk = ~clk;

    logic memread0, memwrite0, iord0, irwrite0, pc_en0, alusrca0, regdst0, memtoreg0, regwrite0;
    logic illegal0, halted0;
    logic [1:0] pcsrc0, alusrcb0, aluop0;
    logic [3:0] state0;
    logic [31:0] cnt0;

    logic memread1, memwrite1, iord1, irwrite1, pc_en1, alusrca1, regdst1, memtoreg1, regwrite1;
    logic illegal1, halted1;
    logic [1:0] pcsrc1, alusrcb1, aluop1;
    logic [3:0] state1;
    logic [31:0] cnt1;

    mips_mc_control #(.ILLEGAL_HALT(1'b0), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .memread(memread0), .memwrite(memwrite0), .iord(iord0), .irwrite(irwrite0),
        .pc_en(pc_en0), .pcsrc(pcsrc0), .alusrca(alusrca0), .alusrcb(alusrcb0),
        .aluop(aluop0), .regdst(regdst0), .memtoreg(memtoreg0), .regwrite(regwrite0),
        .illegal(illegal0), .halted(halted0), .state(state0), .instr_retired(cnt0)
    );

    mips_mc_control #(.ILLEGAL_HALT(1'b1), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .memread(memread1), .memwrite(memwrite1), .iord(iord1), .irwrite(irwrite1),
        .pc_en(pc_en1), .pcsrc(pcsrc1), .alusrca(alusrca1), .alusrcb(alusrcb1),
        .aluop(aluop1), .regdst(regdst1), .memtoreg(memtoreg1), .regwrite(regwrite1),
        .illegal(illegal1), .halted(halted1), .state(state1), .instr_retired(cnt1)
    );

    // {memread,memwrite,iord,irwrite,pc_en,pcsrc,alusrca,alusrcb,aluop,regdst,memtoreg,regwrite,halted}
    logic [15:0] obs0, obs1;
    assign obs0 = {memread0, memwrite0, iord0, irwrite0, pc_en0, pcsrc0, alusrca0, alusrcb0,
                   aluop0, regdst0, memtoreg0, regwrite0, halted0};
    assign obs1 = {memread1, memwrite1, iord1, irwrite1, pc_en1, pcsrc1, alusrca1, alusrcb1,
                   aluop1, regdst1, memtoreg1, regwrite1, halted1};

    typedef struct {
        logic [3:0]  st0, st1;
        logic [31:0] cnt0, cnt1;
        logic        ill0, ill1;
        logic [15:0] out0, out1;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    logic [3:0]  e_st0, e_st1;
    logic [31:0] e_cnt0, e_cnt1;
    logic        e_ill0, e_ill1;

    function automatic logic [15:0] outs(input logic [3:0] s, input logic z);
        logic mr, mw, io, irw, pce, asa, rd, m2r, rw, h;
        logic [1:0] ps, asb, op;
        {mr, mw, io, irw, pce, asa, rd, m2r, rw, h} = '0;
        ps = 2'b00; asb = 2'b00; op = 2'b00;
        case (s)
            4'd1:  begin mr = 1'b1; irw = 1'b1; pce = 1'b1; asb = 2'b01; end
            4'd2:  asb = 2'b11;
            4'd3:  begin asa = 1'b1; asb = 2'b10; end
            4'd4:  begin mr = 1'b1; io = 1'b1; end
            4'd5:  begin m2r = 1'b1; rw = 1'b1; end
            4'd6:  begin mw = 1'b1; io = 1'b1; end
            4'd7:  begin asa = 1'b1; op = 2'b10; end
            4'd8:  begin rd = 1'b1; rw = 1'b1; end
            4'd9:  begin asa = 1'b1; op = 2'b01; ps = 2'b01; pce = z; end
            4'd10: begin asa = 1'b1; asb = 2'b10; end
            4'd11: rw = 1'b1;
            4'd12: begin ps = 2'b10; pce = 1'b1; end
            4'd15: h = 1'b1;
            default: ;
        endcase
        return {mr, mw, io, irw, pce, ps, asa, asb, op, rd, m2r, rw, h};
    endfunction

    task automatic push_exp();
        exp_t e;
        e.st0 = e_st0;  e.st1 = e_st1;
        e.cnt0 = e_cnt0; e.cnt1 = e_cnt1;
        e.ill0 = e_ill0; e.ill1 = e_ill1;
        e.out0 = outs(e_st0, zero);
        e.out1 = outs(e_st1, zero);
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [31:0] o, input logic [31:0] x);
        tests++;
        assert (o === x) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, x);
        end
    endtask

    task automatic check_now();
        exp_t e;
        tests++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL scoreboard_empty: observed %0d expected %0d", 0, 1);
            return;
        end
        e = sb.pop_front();
        cmp("state0",   {28'd0, state0},   {28'd0, e.st0});
        cmp("outs0",    {16'd0, obs0},     {16'd0, e.out0});
        cmp("retired0", cnt0,              e.cnt0);
        cmp("illegal0", {31'd0, illegal0}, {31'd0, e.ill0});
        cmp("state1",   {28'd0, state1},   {28'd0, e.st1});
        cmp("outs1",    {16'd0, obs1},     {16'd0, e.out1});
        cmp("retired1", cnt1,              e.cnt1);
        cmp("illegal1", {31'd0, illegal1}, {31'd0, e.ill1});
        cmp("rd_wr_excl", {31'd0, memread0 & memwrite0}, 32'd0);
    endtask

    task automatic cyc(input logic [3:0] s0, input logic [3:0] s1);
        e_st0 = s0;
        e_st1 = s1;
        push_exp();
        @(posedge clk);
        @(negedge clk);
        check_now();
    endtask

    task automatic clear_exp();
        e_st0 = 4'd0; e_st1 = 4'd0;
        e_cnt0 = '0;  e_cnt1 = '0;
        e_ill0 = 1'b0; e_ill1 = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 6'b000000;
        zero   = 1'b0;
        clear_exp();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push_exp();
            check_now();
        end
        rst_n = 1'b1;
        cyc(4'd1, 4'd1);

        // R-type
        opcode = 6'b000000;
        cyc(4'd2, 4'd2);
        cyc(4'd7, 4'd7);
        cyc(4'd8, 4'd8);
        e_cnt0++; e_cnt1++;
        cyc(4'd1, 4'd1);

        // lw
        opcode = 6'b100011;
        cyc(4'd2, 4'd2);
        cyc(4'd3, 4'd3);
        cyc(4'd4, 4'd4);
        cyc(4'd5, 4'd5);
        e_cnt0++; e_cnt1++;
        cyc(4'd1, 4'd1);

        // sw
        opcode = 6'b101011;
        cyc(4'd2, 4'd2);
        cyc(4'd3, 4'd3);
        cyc(4'd6, 4'd6);
        e_cnt0++; e_cnt1++;
        cyc(4'd1, 4'd1);

        // beq taken
        opcode = 6'b000100;
        zero   = 1'b1;
        cyc(4'd2, 4'd2);
        cyc(4'd9, 4'd9);
        e_cnt0++; e_cnt1++;
        zero = 1'b0;
        cyc(4'd1, 4'd1);

        // beq not taken
        cyc(4'd2, 4'd2);
        cyc(4'd9, 4'd9);
        e_cnt0++; e_cnt1++;
        zero = 1'b1;
        cyc(4'd1, 4'd1);
        zero = 1'b0;

        // addi
        opcode = 6'b001000;
        cyc(4'd2, 4'd2);
        cyc(4'd10, 4'd10);
        cyc(4'd11, 4'd11);
        e_cnt0++; e_cnt1++;
        cyc(4'd1, 4'd1);

        // j
        opcode = 6'b000010;
        cyc(4'd2, 4'd2);
        cyc(4'd12, 4'd12);
        e_cnt0++; e_cnt1++;
        cyc(4'd1, 4'd1);

        // illegal: dut0 skips it, dut1 halts for good
        opcode = 6'b111111;
        cyc(4'd2, 4'd2);
        e_ill0 = 1'b1; e_ill1 = 1'b1;
        cyc(4'd1, 4'd15);
        opcode = 6'b000010;
        cyc(4'd2, 4'd15);
        cyc(4'd12, 4'd15);
        e_cnt0++;
        cyc(4'd1, 4'd15);
        cyc(4'd2, 4'd15);

        // reset pulse recovers both
        rst_n = 1'b0;
        #1;
        clear_exp();
        push_exp();
        check_now();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'd1, 4'd1);

        // async reset in the middle of MEMWR
        opcode = 6'b101011;
        cyc(4'd2, 4'd2);
        cyc(4'd3, 4'd3);
        cyc(4'd6, 4'd6);
        #2;
        rst_n = 1'b0;
        #1;
        clear_exp();
        push_exp();
        check_now();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'd1, 4'd1);

        cmp("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
